// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode encodings, sequencer
// states and the opcode legality check used by the core.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_OUTW   = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  function automatic logic opcode_legal(input logic [3:0] op);
    logic legal;
    case (op)
      OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
      OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: legal = 1'b1;
      default:                              legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/cpu_core_param_if.sv
// Memory bus and output-port handshake between the CPU core (master) and
// its environment (slave).
interface cpu_core_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_re;
  logic              o_mem_we;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic [DATA_W-1:0] o_out;
  logic              o_out_valid;
  logic              i_out_ready;

  modport master (
    output o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata, o_out, o_out_valid,
    input  i_mem_rdata, i_out_ready
  );

  modport slave (
    input  o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata, o_out, o_out_valid,
    output i_mem_rdata, i_out_ready
  );
endinterface

// File: rtl/cpu_alu_flags.sv
// Combinational add/subtract with carry (no-borrow on subtract) and zero.
// The core registers the results.
module cpu_alu_flags #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);
  logic [DATA_W:0]   sum_s;
  logic [DATA_W-1:0] b_s;

  // Subtract as a + ~b + 1 so the carry-out is the no-borrow flag.
  always_comb begin
    b_s    = sub ? ~b : b;
    sum_s  = {1'b0, a} + {1'b0, b_s} + {{DATA_W{1'b0}}, sub};
    result = sum_s[DATA_W-1:0];
    carry  = sum_s[DATA_W];
    zero   = (sum_s[DATA_W-1:0] == {DATA_W{1'b0}});
  end
endmodule

// File: rtl/cpu_core_param.sv
// Parametrised accumulator CPU: fetch/decode/execute sequencer talking to an
// external 1-cycle-latency memory, with handshaked output and single-step.
module cpu_core_param
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RESET_PC = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  cpu_core_param_if.master  bus,
  input  logic              i_step_en,
  input  logic              i_step,
  output logic              o_halted,
  output logic              o_illegal,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_flag_c,
  output logic              o_flag_z
);
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  state_e            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] ir_r;
  logic              c_r;
  logic              z_r;
  logic [DATA_W-1:0] out_r;
  logic              out_valid_r;
  logic              halted_r;

  logic [3:0]        opcode_s;
  logic [ADDR_W-1:0] operand_s;
  logic              fetch_go_s;
  logic              sub_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              alu_c_s;
  logic              alu_z_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic              mem_re_s;
  logic              mem_we_s;
  logic              illegal_s;
  logic              unused_s;

  assign opcode_s   = ir_r[DATA_W-1 -: 4];
  assign operand_s  = ir_r[ADDR_W-1:0];
  assign fetch_go_s = (state_r == ST_FETCH) && (!i_step_en || i_step);
  assign sub_s      = (opcode_s == OP_SUB);
  // B is architectural state only; the middle IR bits carry no meaning.
  assign unused_s   = ^{b_r, ir_r};

  cpu_alu_flags #(.DATA_W(DATA_W)) u_alu (
    .a      (a_r),
    .b      (bus.i_mem_rdata),
    .sub    (sub_s),
    .result (alu_res_s),
    .carry  (alu_c_s),
    .zero   (alu_z_s)
  );

  // Memory strobes follow the current state; reset forces them low at once.
  always_comb begin
    mem_addr_s = '0;
    mem_re_s   = 1'b0;
    mem_we_s   = 1'b0;
    if (!i_rst) begin
      mem_re_s = 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (fetch_go_s) begin
            mem_addr_s = pc_r;
            mem_re_s   = 1'b1;
          end else begin
            mem_re_s   = 1'b0;
          end
        end
        ST_EXEC: begin
          case (opcode_s)
            OP_LDA, OP_ADD, OP_SUB: begin
              mem_addr_s = operand_s;
              mem_re_s   = 1'b1;
            end
            OP_STA: begin
              mem_addr_s = operand_s;
              mem_we_s   = 1'b1;
            end
            default: mem_re_s = 1'b0;
          endcase
        end
        default: mem_re_s = 1'b0;
      endcase
    end
  end

  assign illegal_s = i_rst && (state_r == ST_EXEC) && !opcode_legal(opcode_s);

  // Instruction sequencer and architectural registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r     <= ST_FETCH;
      pc_r        <= PC_INIT;
      a_r         <= '0;
      b_r         <= '0;
      ir_r        <= '0;
      c_r         <= 1'b0;
      z_r         <= 1'b0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (fetch_go_s) state_r <= ST_DECODE;
          else            state_r <= ST_FETCH;
        end
        ST_DECODE: begin
          ir_r    <= bus.i_mem_rdata;
          pc_r    <= pc_r + ADDR_W'(1);
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          state_r <= ST_FETCH;
          case (opcode_s)
            OP_LDI: a_r <= {{(DATA_W-ADDR_W){1'b0}}, operand_s};
            OP_JMP: pc_r <= operand_s;
            OP_JC: begin
              if (c_r) pc_r <= operand_s;
              else     pc_r <= pc_r;
            end
            OP_JZ: begin
              if (z_r) pc_r <= operand_s;
              else     pc_r <= pc_r;
            end
            OP_LDA, OP_ADD, OP_SUB: state_r <= ST_MEM;
            OP_OUT: begin
              out_r       <= a_r;
              out_valid_r <= 1'b1;
              state_r     <= ST_OUTW;
            end
            OP_HLT: begin
              halted_r <= 1'b1;
              state_r  <= ST_HALT;
            end
            default: state_r <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          b_r     <= bus.i_mem_rdata;
          state_r <= ST_FETCH;
          case (opcode_s)
            OP_LDA: a_r <= bus.i_mem_rdata;
            OP_ADD, OP_SUB: begin
              a_r <= alu_res_s;
              c_r <= alu_c_s;
              z_r <= alu_z_s;
            end
            default: a_r <= a_r;
          endcase
        end
        ST_OUTW: begin
          if (bus.i_out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_FETCH;
          end else begin
            state_r     <= ST_OUTW;
          end
        end
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_FETCH;
      endcase
    end
  end

  assign bus.o_mem_addr  = mem_addr_s;
  assign bus.o_mem_re    = mem_re_s;
  assign bus.o_mem_we    = mem_we_s;
  assign bus.o_mem_wdata = a_r;
  assign bus.o_out       = out_r;
  assign bus.o_out_valid = out_valid_r;

  assign o_halted  = halted_r;
  assign o_illegal = illegal_s;
  assign o_pc      = pc_r;
  assign o_flag_c  = c_r;
  assign o_flag_z  = z_r;

endmodule

// File: tb/tb_cpu_core_param.sv
// Bench for cpu_core_param: directed program table, hand-built multi-cycle
// sequences, and random programs checked against an instruction-level model.
module tb_cpu_core_param;

  typedef logic [7:0] prog_t [16];

  typedef struct {
    logic [15:0][7:0] prog;
    int k;
    int e_a;
    int e_c;
    int e_z;
    int e_pc;
    int e_out;
    int e_nout;
    int e_ill;
    int e_cyc;
    int m_addr;
    int e_mval;
  } vec_t;

  localparam int NV = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       step_en;
  logic       step;
  logic       halted;
  logic       illegal;
  logic       flag_c;
  logic       flag_z;
  logic [3:0] pc;

  cpu_core_param_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  cpu_core_param #(.DATA_W(8), .ADDR_W(4), .RESET_PC(0)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .bus       (bus),
    .i_step_en (step_en),
    .i_step    (step),
    .o_halted  (halted),
    .o_illegal (illegal),
    .o_pc      (pc),
    .o_flag_c  (flag_c),
    .o_flag_z  (flag_z)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];
  prog_t      prog_buf;
  logic       load_req = 1'b0;

  // Synchronous single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 16; i++) mem[i] <= prog_buf[i];
    end else begin
      if (bus.o_mem_re) bus.i_mem_rdata <= mem[bus.o_mem_addr];
      if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
    end
  end

  int total = 0;
  int bad   = 0;
  int ill_cnt;
  int viol;
  logic [7:0] out_q [$];

  // instruction-level reference model state
  int  m_mem [16];
  int  m_a, m_c, m_z, m_pc, m_cyc, m_ill;
  bit  m_halt;
  int  m_outs [$];

  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input prog_t p, input logic se);
    rst             = 1'b0;
    step            = 1'b0;
    step_en         = se;
    bus.i_out_ready = 1'b0;
    prog_buf        = p;
    load_req        = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Runs until halted or budget; consumer raises ready after k cycles of valid.
  task automatic run_prog(input int k, input int budget, output int cycles, output bit done);
    int vcnt;
    bit prev_we;
    cycles = 0; done = 1'b0; vcnt = 0; prev_we = 1'b0;
    ill_cnt = 0; viol = 0; out_q.delete();
    while (cycles < budget && !done) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.o_mem_re && bus.o_mem_we) viol++;
      if (bus.o_mem_we && prev_we) viol++;
      prev_we = bus.o_mem_we;
      if (illegal) ill_cnt++;
      if (bus.o_out_valid) begin
        vcnt++;
        if (vcnt > k) begin
          bus.i_out_ready = 1'b1;
          out_q.push_back(bus.o_out);
        end else begin
          bus.i_out_ready = 1'b0;
        end
      end else begin
        vcnt = 0;
        bus.i_out_ready = 1'b0;
      end
      if (halted) done = 1'b1;
    end
    bus.i_out_ready = 1'b0;
  endtask

  task automatic model_run(input prog_t p, input int k);
    int w, op, arg, s;
    for (int i = 0; i < 16; i++) m_mem[i] = int'(p[i]);
    m_a = 0; m_c = 0; m_z = 0; m_pc = 0; m_cyc = 0; m_ill = 0; m_halt = 1'b0;
    m_outs.delete();
    for (int n = 0; n < 100 && !m_halt; n++) begin
      w = m_mem[m_pc]; op = w / 16; arg = w % 16;
      m_pc = (m_pc + 1) % 16;
      m_cyc += 3;
      case (op)
        0: ;
        1: begin m_a = m_mem[arg]; m_cyc += 1; end
        2: begin
          s = m_a + m_mem[arg];
          m_c = (s > 255) ? 1 : 0; m_a = s % 256; m_z = (m_a == 0) ? 1 : 0; m_cyc += 1;
        end
        3: begin
          s = m_mem[arg];
          m_c = (m_a >= s) ? 1 : 0; m_a = (m_a - s + 256) % 256; m_z = (m_a == 0) ? 1 : 0; m_cyc += 1;
        end
        4: m_mem[arg] = m_a;
        5: m_a = arg;
        6: m_pc = arg;
        7: if (m_c == 1) m_pc = arg;
        8: if (m_z == 1) m_pc = arg;
        14: begin m_outs.push_back(m_a); m_cyc += k + 1; end
        15: m_halt = 1'b1;
        default: m_ill++;
      endcase
    end
  endtask

  task automatic set_vec(input int v, input int k, input int a, input int c, input int z,
                         input int vpc, input int o, input int no, input int il, input int cy,
                         input int ma, input int mv);
    vt[v].k = k; vt[v].e_a = a; vt[v].e_c = c; vt[v].e_z = z; vt[v].e_pc = vpc;
    vt[v].e_out = o; vt[v].e_nout = no; vt[v].e_ill = il; vt[v].e_cyc = cy;
    vt[v].m_addr = ma; vt[v].e_mval = mv;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prog_t p;
    int    cyc, cnt;
    bit    done, seen;

    for (int v = 0; v < NV; v++) vt[v].prog = '0;
    // LDI 5; OUT; HLT
    vt[0].prog[0] = 8'h55; vt[0].prog[1] = 8'hE0; vt[0].prog[2] = 8'hF0;
    set_vec(0, 0, 5, 0, 0, 3, 5, 1, 0, 10, 0, 8'h55);
    // LDA 14; ADD 15 (0xFF+1); JC 5; HLT; HLT; OUT; HLT
    vt[1].prog[0] = 8'h1E; vt[1].prog[1] = 8'h2F; vt[1].prog[2] = 8'h75;
    vt[1].prog[3] = 8'hF0; vt[1].prog[4] = 8'hF0; vt[1].prog[5] = 8'hE0;
    vt[1].prog[6] = 8'hF0; vt[1].prog[14] = 8'hFF; vt[1].prog[15] = 8'h01;
    set_vec(1, 0, 0, 1, 1, 7, 0, 1, 0, 18, 14, 8'hFF);
    // LDI 7; STA 12; SUB 12; HLT
    vt[2].prog[0] = 8'h57; vt[2].prog[1] = 8'h4C; vt[2].prog[2] = 8'h3C; vt[2].prog[3] = 8'hF0;
    set_vec(2, 0, 0, 1, 1, 4, 0, 0, 0, 13, 12, 7);
    // illegal 1010; LDI 3; HLT
    vt[3].prog[0] = 8'hA0; vt[3].prog[1] = 8'h53; vt[3].prog[2] = 8'hF0;
    set_vec(3, 0, 3, 0, 0, 3, 0, 0, 1, 9, 0, 8'hA0);
    // JC 4 (not taken); LDA 14; ADD 13; JMP 15; NOP@15 wraps; JC 4 taken; HLT
    vt[4].prog[0] = 8'h74; vt[4].prog[1] = 8'h1E; vt[4].prog[2] = 8'h2D;
    vt[4].prog[3] = 8'h6F; vt[4].prog[4] = 8'hF0; vt[4].prog[13] = 8'h01; vt[4].prog[14] = 8'hFF;
    set_vec(4, 0, 0, 1, 1, 5, 0, 0, 0, 23, 15, 0);
    // LDI 3; SUB 15 (borrow); JZ 0 not taken; OUT with 3 stall cycles; HLT
    vt[5].prog[0] = 8'h53; vt[5].prog[1] = 8'h3F; vt[5].prog[2] = 8'h80;
    vt[5].prog[3] = 8'hE0; vt[5].prog[4] = 8'hF0; vt[5].prog[15] = 8'h05;
    set_vec(5, 3, 8'hFE, 0, 0, 5, 8'hFE, 1, 0, 20, 15, 5);
    // LDI 2; ADD 14; SUB 15; JZ 5 taken; HLT; OUT; HLT
    vt[6].prog[0] = 8'h52; vt[6].prog[1] = 8'h2E; vt[6].prog[2] = 8'h3F; vt[6].prog[3] = 8'h85;
    vt[6].prog[4] = 8'hF0; vt[6].prog[5] = 8'hE0; vt[6].prog[6] = 8'hF0;
    vt[6].prog[14] = 8'h03; vt[6].prog[15] = 8'h05;
    set_vec(6, 1, 0, 1, 1, 7, 0, 1, 0, 22, 15, 5);

    // reset values
    for (int j = 0; j < 16; j++) p[j] = vt[0].prog[j];
    rst = 1'b0; step = 1'b0; step_en = 1'b0; bus.i_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_flags", 32'({flag_c, flag_z}), 32'd0);
    chk("rst_out", 32'({bus.o_out_valid, bus.o_out}), 32'd0);
    chk("rst_status", 32'({halted, illegal}), 32'd0);
    chk("rst_strobes", 32'({bus.o_mem_re, bus.o_mem_we}), 32'd0);
    chk("rst_a", 32'(bus.o_mem_wdata), 32'd0);
    do_reset(p, 1'b0);
    #1;
    chk("first_fetch", 32'({bus.o_mem_re, bus.o_mem_addr}), 32'h10);

    // directed table
    for (int v = 0; v < NV; v++) begin
      for (int j = 0; j < 16; j++) p[j] = vt[v].prog[j];
      do_reset(p, 1'b0);
      run_prog(vt[v].k, 100, cyc, done);
      chk($sformatf("v%0d_done", v), 32'(done), 32'd1);
      chk($sformatf("v%0d_cycles", v), 32'(cyc), 32'(vt[v].e_cyc));
      chk($sformatf("v%0d_a", v), 32'(bus.o_mem_wdata), 32'(vt[v].e_a));
      chk($sformatf("v%0d_c", v), 32'(flag_c), 32'(vt[v].e_c));
      chk($sformatf("v%0d_z", v), 32'(flag_z), 32'(vt[v].e_z));
      chk($sformatf("v%0d_pc", v), 32'(pc), 32'(vt[v].e_pc));
      chk($sformatf("v%0d_out", v), 32'(bus.o_out), 32'(vt[v].e_out));
      chk($sformatf("v%0d_nout", v), 32'(out_q.size()), 32'(vt[v].e_nout));
      chk($sformatf("v%0d_ill", v), 32'(ill_cnt), 32'(vt[v].e_ill));
      chk($sformatf("v%0d_mem", v), 32'(mem[vt[v].m_addr]), 32'(vt[v].e_mval));
      chk($sformatf("v%0d_bus_rules", v), 32'(viol), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("v%0d_frozen", v), 32'({halted, pc, bus.o_mem_re}), 32'({1'b1, 4'(vt[v].e_pc), 1'b0}));
    end

    // OUT stall: ready low while valid, then handshake
    for (int j = 0; j < 16; j++) p[j] = 8'h00;
    p[0] = 8'h59; p[1] = 8'hE0; p[2] = 8'hF0;
    do_reset(p, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.o_out_valid) seen = 1'b1;
    end
    chk("outw_seen", 32'(seen), 32'd1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.o_out_valid && bus.o_out == 8'h09 && !bus.o_mem_re && !bus.o_mem_we) cnt++;
    end
    chk("outw_held", 32'(cnt), 32'd5);
    bus.i_out_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_out_ready = 1'b0;
    chk("outw_drop", 32'(bus.o_out_valid), 32'd0);
    chk("outw_keep", 32'(bus.o_out), 32'h09);
    chk("outw_fetch", 32'({bus.o_mem_re, bus.o_mem_addr}), 32'h12);

    // reset asserted mid-OUTW
    do_reset(p, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.o_out_valid) seen = 1'b1;
    end
    chk("rstw_seen", 32'(seen), 32'd1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("rstw_out", 32'({bus.o_out_valid, bus.o_out}), 32'd0);
    chk("rstw_pc", 32'(pc), 32'd0);
    chk("rstw_misc", 32'({halted, bus.o_mem_re, bus.o_mem_we, bus.o_mem_wdata}), 32'd0);

    // single step: two accepted pulses retire exactly two instructions
    for (int j = 0; j < 16; j++) p[j] = 8'h00;
    p[0] = 8'h55; p[1] = 8'h56; p[2] = 8'h57; p[3] = 8'hF0;
    do_reset(p, 1'b1);
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.o_mem_re) cnt++;
    end
    chk("step_idle_re", 32'(cnt), 32'd0);
    chk("step_idle_pc", 32'(pc), 32'd0);
    @(negedge clk); step = 1'b1;
    @(negedge clk);
    @(negedge clk); step = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("step1_pc", 32'(pc), 32'd1);
    chk("step1_a", 32'(bus.o_mem_wdata), 32'd5);
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("step2_pc", 32'(pc), 32'd2);
    chk("step2_a", 32'(bus.o_mem_wdata), 32'd6);
    chk("step2_halt", 32'(halted), 32'd0);

    // random programs against the instruction-level model
    for (int r = 0; r < 20; r++) begin
      int  k;
      bit  ok;
      ok = 1'b0; k = 0;
      for (int t = 0; t < 100 && !ok; t++) begin
        for (int i = 0; i < 16; i++) p[i] = 8'($urandom_range(0, 255));
        k = $urandom_range(0, 3);
        model_run(p, k);
        ok = m_halt;
      end
      chk($sformatf("r%0d_gen", r), 32'(ok), 32'd1);
      do_reset(p, 1'b0);
      run_prog(k, m_cyc + 40, cyc, done);
      chk($sformatf("r%0d_done", r), 32'(done), 32'd1);
      chk($sformatf("r%0d_cycles", r), 32'(cyc), 32'(m_cyc));
      chk($sformatf("r%0d_a", r), 32'(bus.o_mem_wdata), 32'(m_a));
      chk($sformatf("r%0d_c", r), 32'(flag_c), 32'(m_c));
      chk($sformatf("r%0d_z", r), 32'(flag_z), 32'(m_z));
      chk($sformatf("r%0d_pc", r), 32'(pc), 32'(m_pc));
      chk($sformatf("r%0d_ill", r), 32'(ill_cnt), 32'(m_ill));
      chk($sformatf("r%0d_bus_rules", r), 32'(viol), 32'd0);
      chk($sformatf("r%0d_nout", r), 32'(out_q.size()), 32'(m_outs.size()));
      for (int i = 0; i < out_q.size() && i < m_outs.size(); i++)
        chk($sformatf("r%0d_out%0d", r, i), 32'(out_q[i]), 32'(m_outs[i]));
      for (int i = 0; i < 16; i++)
        chk($sformatf("r%0d_mem%0d", r, i), 32'(mem[i]), 32'(m_mem[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
